// File: rtl/cmsdk_mcu_mtx_arb_rr_pkg.sv
// Shared definitions for the MCU bus-matrix output stages: AHB encodings,
// arbiter state type and fixed-length burst beat counts.
package cmsdk_mcu_mtx_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    LOCK  = 2'b01,
    BURST = 2'b10
  } arb_state_t;

  // Counts are SEQ beats remaining after the NONSEQ beat.
  localparam logic [3:0] BEATS_4  = 4'd3;
  localparam logic [3:0] BEATS_8  = 4'd7;
  localparam logic [3:0] BEATS_16 = 4'd15;

  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    beats = 4'd0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = BEATS_4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = BEATS_8;
      HBURST_WRAP16, HBURST_INCR16: beats = BEATS_16;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/cmsdk_mcu_mtx_arb_rr_if.sv
// Output-stage arbitration bundle: per-port requests and output-port transfer
// status in, address mux select and no-port indication out.
interface cmsdk_mcu_mtx_arb_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
);

  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port
  );

endinterface

// File: rtl/cmsdk_mcu_mtx_rr_pick.sv
// Combinational rotating search: first set request after last_grant, wrapping.
// Shared by any output stage that needs round-robin selection.
module cmsdk_mcu_mtx_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_grant,
  output logic [PORT_W-1:0]    winner,
  output logic                 valid
);

  logic [PORT_W-1:0] idx;

  // Offsets 1..NUM_PORTS so the previous winner is visited last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PORT_W'((int'(last_grant) + k) % NUM_PORTS);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmsdk_mcu_mtx_arb_rr.sv
// Round-robin output-stage arbiter with lock hold and, when
// CMSDK_MTX_ARB_BURST_HOLD_EN is defined, fixed-length burst hold.
module cmsdk_mcu_mtx_arb_rr
  import cmsdk_mcu_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  cmsdk_mcu_mtx_arb_rr_if.slave bus
);

  arb_state_t        state, state_nxt;
  logic [PORT_W-1:0] last_grant, last_grant_nxt;
  logic [PORT_W-1:0] addr_q, addr_nxt;
  logic              no_port_q, no_port_nxt;
  logic              rearb;
  logic [PORT_W-1:0] pick_winner;
  logic              pick_valid;

`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       burst_start;

  assign burst_start = bus.HSELM && (bus.HTRANSM == HTRANS_NONSEQ) &&
                       (burst_beats(bus.HBURSTM) != 4'd0);
`else
  logic unused_burst_ok;
  assign unused_burst_ok = ^{bus.HTRANSM, bus.HBURSTM};
`endif

  cmsdk_mcu_mtx_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req        (bus.req_port),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // rearb marks an edge where the next owner is chosen; every other path holds.
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_q;
    no_port_nxt    = no_port_q;
    last_grant_nxt = last_grant;
    rearb          = 1'b0;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
    beat_cnt_nxt   = beat_cnt;
`endif

    if (bus.HMASTLOCKM) begin
      state_nxt = LOCK;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
      beat_cnt_nxt = 4'd0;
`endif
    end else begin
      case (state)
        LOCK: rearb = 1'b1;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
        BURST: begin
          if (bus.HTRANSM == HTRANS_SEQ) begin
            if (beat_cnt > 4'd1) begin
              beat_cnt_nxt = beat_cnt - 4'd1;
            end else begin
              beat_cnt_nxt = 4'd0;
              rearb        = 1'b1;
            end
          end else if (bus.HTRANSM == HTRANS_BUSY) begin
            beat_cnt_nxt = beat_cnt;
          end else begin
            beat_cnt_nxt = 4'd0;
            rearb        = 1'b1;
          end
        end
`endif
        default: rearb = 1'b1;
      endcase
    end

    if (rearb) begin
      state_nxt = ARB;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
      if (burst_start) begin
        state_nxt    = BURST;
        beat_cnt_nxt = burst_beats(bus.HBURSTM);
        no_port_nxt  = 1'b0;
      end else
`endif
      if (pick_valid) begin
        addr_nxt       = pick_winner;
        last_grant_nxt = pick_winner;
        no_port_nxt    = 1'b0;
      end else begin
        no_port_nxt = !bus.HSELM;
      end
    end
  end

  // Everything advances only on edges that complete an output transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ARB;
      addr_q     <= '0;
      no_port_q  <= 1'b1;
      last_grant <= PORT_W'(NUM_PORTS - 1);
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
      beat_cnt   <= 4'd0;
`endif
    end else if (bus.HREADYM) begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      no_port_q  <= no_port_nxt;
      last_grant <= last_grant_nxt;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
      beat_cnt   <= beat_cnt_nxt;
`endif
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;

endmodule

// File: tb/tb_cmsdk_mcu_mtx_arb_rr.sv
// Bench for cmsdk_mcu_mtx_arb_rr: transfer-level reference model compared every
// cycle, plus literal checkpoints; burst-hold expectations follow CMSDK_MTX_ARB_BURST_HOLD_EN.
module tb_cmsdk_mcu_mtx_arb_rr;
  import cmsdk_mcu_mtx_pkg::*;

  localparam int NP = 4;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
  localparam bit BH = 1'b1;
`else
  localparam bit BH = 1'b0;
`endif

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 HCLK = ~HCLK;

  cmsdk_mcu_mtx_arb_rr_if #(.NUM_PORTS(NP), .PORT_W(2)) bus ();

  cmsdk_mcu_mtx_arb_rr #(.NUM_PORTS(NP), .PORT_W(2)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  typedef struct packed {
    int addr;
    bit no;
    int last;
    bit lock;
    bit burst;
    int beats;
  } model_t;

  model_t m;

  function automatic int rr_search(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (req[p[1:0]]) return p;
    end
    return -1;
  endfunction

  // One completed transfer: who owns the next address phase.
  function automatic model_t model_step(input model_t cur, input logic [NP-1:0] req,
                                        input logic sel, input logic [1:0] trans,
                                        input logic [2:0] hb, input logic lock);
    model_t n;
    bit     open_slot;
    int     w;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
    int     h;
`endif
    n = cur;
    open_slot = 1'b1;
    if (lock) begin
      n.lock  = 1'b1;
      n.burst = 1'b0;
      return n;
    end
    n.lock = 1'b0;
`ifdef CMSDK_MTX_ARB_BURST_HOLD_EN
    if (cur.burst) begin
      if (trans == 2'b11 && cur.beats > 1) begin
        n.beats   = cur.beats - 1;
        open_slot = 1'b0;
      end else if (trans == 2'b01) begin
        open_slot = 1'b0;
      end else begin
        n.burst = 1'b0;
      end
    end
    if (!open_slot) return n;
    h = int'(hb);
    if (sel && trans == 2'b10 && h >= 2) begin
      n.burst = 1'b1;
      n.beats = (4 << ((h - 2) / 2)) - 1;
      n.no    = 1'b0;
      return n;
    end
`endif
    if (!open_slot) return n;
    w = rr_search(req, cur.last);
    if (w >= 0) begin
      n.addr = w;
      n.last = w;
      n.no   = 1'b0;
    end else begin
      n.no = !sel;
    end
    return n;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m <= '{addr: 0, no: 1'b1, last: NP - 1, lock: 1'b0, burst: 1'b0, beats: 0};
    end else if (bus.HREADYM) begin
      m <= model_step(m, bus.req_port, bus.HSELM, bus.HTRANSM, bus.HBURSTM, bus.HMASTLOCKM);
    end
  end

  always @(negedge HCLK) begin
    checks++;
    if (bus.addr_in_port !== 2'(m.addr) || bus.no_port !== m.no) begin
      errors++;
      $display("[TB] FAIL model_cmp t=%0t addr_in_port=%0d no_port=%0d expected %0d/%0d",
               $time, bus.addr_in_port, bus.no_port, m.addr, m.no);
    end
  end

  task automatic apply_stimulus(input logic [NP-1:0] req, input logic ready, input logic sel,
                                input logic [1:0] trans, input logic [2:0] hb, input logic lock);
    bus.req_port   = req;
    bus.HREADYM    = ready;
    bus.HSELM      = sel;
    bus.HTRANSM    = trans;
    bus.HBURSTM    = hb;
    bus.HMASTLOCKM = lock;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #2;
  endtask

  task automatic check_output(input string name, input logic [1:0] exp_addr, input logic exp_no);
    checks++;
    if (bus.addr_in_port !== exp_addr || bus.no_port !== exp_no) begin
      errors++;
      $display("[TB] FAIL %s addr_in_port=%0d no_port=%0d expected %0d/%0d",
               name, bus.addr_in_port, bus.no_port, exp_addr, exp_no);
    end
  endtask

  initial begin
    apply_stimulus(4'b0000, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick(2);
    check_output("reset", 2'd0, 1'b0 ^ 1'b1);
    HRESETn = 1'b1;

    // Full request set rotates 0,1,2,3,0.
    apply_stimulus(4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("rr_0", 2'd0, 1'b0);
    tick(1); check_output("rr_1", 2'd1, 1'b0);
    tick(1); check_output("rr_2", 2'd2, 1'b0);
    tick(1); check_output("rr_3", 2'd3, 1'b0);
    tick(1); check_output("rr_wrap", 2'd0, 1'b0);

    // Sparse requests, with a stall in the middle.
    apply_stimulus(4'b0101, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("sparse_2", 2'd2, 1'b0);
    tick(1); check_output("sparse_0", 2'd0, 1'b0);
    bus.HREADYM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1); check_output("stall", 2'd0, 1'b0);
    end
    bus.HREADYM = 1'b1;
    tick(1); check_output("sparse_2b", 2'd2, 1'b0);

    // Lock holds port 1 against other requests.
    apply_stimulus(4'b0010, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("pre_lock", 2'd1, 1'b0);
    apply_stimulus(4'b1101, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1); check_output("lock_hold", 2'd1, 1'b0);
    end
    bus.HMASTLOCKM = 1'b0;
    tick(1); check_output("unlock", 2'd2, 1'b0);

    // No requests: hold while selected, then release.
    apply_stimulus(4'b0000, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("idle_sel", 2'd2, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick(1); check_output("idle_nosel", 2'd2, 1'b1);

    // INCR4 from port 0 with port 1 waiting.
    apply_stimulus(4'b0001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("b_pre", 2'd0, 1'b0);
    apply_stimulus(4'b0010, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
    tick(1); check_output("b_nonseq", BH ? 2'd0 : 2'd1, 1'b0);
    bus.HTRANSM = HTRANS_SEQ;
    tick(1); check_output("b_seq1", BH ? 2'd0 : 2'd1, 1'b0);
    tick(1); check_output("b_seq2", BH ? 2'd0 : 2'd1, 1'b0);
    tick(1); check_output("b_end", 2'd1, 1'b0);

    // Early termination by IDLE.
    apply_stimulus(4'b0001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("e_pre", 2'd0, 1'b0);
    apply_stimulus(4'b0010, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
    tick(1); check_output("e_nonseq", BH ? 2'd0 : 2'd1, 1'b0);
    bus.HTRANSM = HTRANS_SEQ;
    tick(1); check_output("e_seq", BH ? 2'd0 : 2'd1, 1'b0);
    bus.HTRANSM = HTRANS_IDLE;
    tick(1); check_output("early", 2'd1, 1'b0);

    // Asynchronous reset in the middle of a WRAP8.
    apply_stimulus(4'b0001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick(1); check_output("w_pre", 2'd0, 1'b0);
    apply_stimulus(4'b0010, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_WRAP8, 1'b0);
    tick(1); check_output("w_nonseq", BH ? 2'd0 : 2'd1, 1'b0);
    bus.HTRANSM = HTRANS_SEQ;
    tick(2); check_output("w_seq", BH ? 2'd0 : 2'd1, 1'b0);
    HRESETn = 1'b0;
    #1 check_output("async_rst", 2'd0, 1'b1);
    tick(1);
    HRESETn = 1'b1;

    // Fresh arbitration, then a WRAP8 with BUSY beats.
    apply_stimulus(4'b0010, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick(1); check_output("post_rst", 2'd1, 1'b0);
    apply_stimulus(4'b0001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_WRAP8, 1'b0);
    tick(1); check_output("w2_start", BH ? 2'd1 : 2'd0, 1'b0);
    bus.HTRANSM = HTRANS_SEQ;  tick(1);
    bus.HTRANSM = HTRANS_BUSY; tick(1);
    bus.HTRANSM = HTRANS_SEQ;  tick(1);
    check_output("busy_hold", BH ? 2'd1 : 2'd0, 1'b0);
    bus.HTRANSM = HTRANS_IDLE;
    tick(1); check_output("w2_end", 2'd0, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick(2); check_output("final_idle", 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
